weight_stream_memory: RTL and testbench

Parametrised, runtime-writable weight store for the fully-connected layers. On a start request it streams one weight row (all OUTPUT_NODES weights belonging to one input node) to the MAC array as OUTPUT_NODES/LANES beats of LANES weights each, under a valid/ready handshake. It replaces whole-row, single-cycle weight fetch with a lane-width stream. A write port allows weights to be reloaded without re-synthesis.

---
 rtl/weight_stream_memory.sv | 137 +++++++++++++
 tb/tb_weight_stream_memory.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_memory.sv
// weight_stream_memory
//   Runtime-writable weight store. A start request streams one weight row
//   (OUTPUT_NODES words belonging to one input node) as BEATS beats of LANES
//   words each over a valid/ready interface.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, row        stream request and row index (sampled together)
//   busy              high while a row is being fetched/streamed
//   out_valid/ready   beat handshake
//   out_data          current beat, lane 0 in the MSBs
//   out_last          marks the final beat of the row
//   err               one-cycle pulse for a start with an out-of-range row
//   wr_en/addr/data   word write port (flat address row*OUTPUT_NODES + col)
//   fsm_state         current FSM state for observation
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready
// are both high. Once out_valid is raised, out_data and out_last stay
// stable until that transfer happens.
module weight_stream_memory #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    INPUT_NODES  = 100,
  parameter int    OUTPUT_NODES = 32,
  parameter int    LANES        = 8,
  parameter string INIT_FILE    = "",
  localparam int   BEATS  = OUTPUT_NODES / LANES,
  localparam int   DEPTH  = INPUT_NODES * OUTPUT_NODES,
  localparam int   ROW_W  = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1,
  localparam int   ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ROW_W-1:0]            row,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic                        out_last,
  output logic                        err,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [1:0]                  fsm_state
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (OUTPUT_NODES % LANES != 0) begin : g_bad_lanes
    $error("OUTPUT_NODES must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t                      state;
  logic [ROW_W-1:0]            row_q;
  logic [BEAT_W-1:0]           beat;
  logic [BEAT_W-1:0]           load_beat;
  logic [ADDR_W-1:0]           word_addr;
  logic [DATA_WIDTH*LANES-1:0] beat_data;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];

  assign fsm_state = state;

  // Memory is not reset; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Beat to be loaded on this edge: beat 0 from FETCH, the next one from
  // STREAM. The read is combinational against the array, so a write on the
  // same edge lands after the load and the beat carries the old word.
  always_comb begin
    load_beat = (state == FETCH) ? '0 : beat + 1'b1;
    beat_data = '0;
    word_addr = '0;
    for (int j = 0; j < LANES; j++) begin
      word_addr = ADDR_W'(32'(row_q) * OUTPUT_NODES + 32'(load_beat) * LANES + j);
      beat_data[(LANES-1-j)*DATA_WIDTH +: DATA_WIDTH] = mem[word_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_q     <= '0;
      beat      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (32'(row) < INPUT_NODES) begin
              row_q <= row;
              beat  <= '0;
              busy  <= 1'b1;
              state <= FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          out_data  <= beat_data;
          out_valid <= 1'b1;
          out_last  <= (BEATS == 1);
          beat      <= '0;
          state     <= STREAM;
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              // Next beat loads on the handshake edge: no bubble.
              out_data <= beat_data;
              beat     <= load_beat;
              out_last <= (32'(beat) + 32'd2 == 32'(BEATS));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_memory.sv
module tb_weight_stream_memory;

  localparam int DW     = 32;
  localparam int IN_N   = 100;
  localparam int OUT_N  = 32;
  localparam int LANES  = 8;
  localparam int BEATS  = OUT_N / LANES;
  localparam int DEPTH  = IN_N * OUT_N;
  localparam int ROW_W  = $clog2(IN_N);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BW     = DW * LANES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ROW_W-1:0]  row;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic              out_last;
  logic              err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        fsm_state;

  int compares = 0;
  int fails    = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [BW-1:0] exp_q[$];

  weight_stream_memory #(
    .DATA_WIDTH(DW), .INPUT_NODES(IN_N), .OUTPUT_NODES(OUT_N),
    .LANES(LANES), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    compares++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"},  out_last,  0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_err"},   err,       0);
    check({tag, "_data"},  out_data,  0);
  endtask

  // Expected row as beats: lane j of beat b is word r*OUT_N + b*LANES + j,
  // lane 0 in the most significant slot.
  task automatic build_exp(input int r);
    logic [BW-1:0] b_word;
    for (int b = 0; b < BEATS; b++) begin
      b_word = '0;
      for (int j = 0; j < LANES; j++)
        b_word[(LANES-1-j)*DW +: DW] = model_mem[r*OUT_N + b*LANES + j];
      exp_q.push_back(b_word);
    end
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr < DEPTH) model_mem[addr] = data;
  endtask

  // mode 0: ready always 1; 1: pattern 1,0,0 repeating; 2: random.
  // poke: re-assert start while busy; coll: write word 45 on beat-1 load edge.
  task automatic run_row(input int r, input int mode, input bit poke, input bit coll);
    int  cyc;
    int  hs;
    bit  rdy;
    build_exp(r);
    start = 1'b1; row = ROW_W'(r);
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", out_valid, 0);
    check("start_err", err, 0);
    tick();
    cyc = 0; hs = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 1) begin
        start = 1'b1; row = ROW_W'($urandom_range(0, IN_N-1));
      end
      if (coll && cyc == 0) begin
        wr_en = 1'b1; wr_addr = ADDR_W'(45); wr_data = 32'hCAFE0045;
      end
      out_ready = rdy;
      check("stream_valid", out_valid, 1);
      check("stream_busy", busy, 1);
      check("stream_err", err, 0);
      check("beat_data", out_data, exp_q[0]);
      check("beat_last", out_last, (exp_q.size() == 1));
      if (coll && hs == 1) begin
        check("coll_lane0", out_data[(LANES-1)*DW +: DW], 32'hDEADBEEF);
        check("coll_lane5_old", out_data[(LANES-1-5)*DW +: DW], 45);
      end
      tick();
      start = 1'b0;
      if (coll && cyc == 0) begin
        wr_en = 1'b0;
        model_mem[45] = 32'hCAFE0045;
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        hs++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    check("stream_timeout", exp_q.size(), 0);
    check("handshakes", hs, BEATS);
    exp_q.delete();
    check("end_busy", busy, 0);
    check("end_valid", out_valid, 0);
    check("end_last", out_last, 0);
    // No second stream may start on its own.
    repeat (2) begin
      tick();
      check("after_valid", out_valid, 0);
      check("after_busy", busy, 0);
      check("after_err", err, 0);
    end
  endtask

  initial begin
    int r;
    rst_n = 1'b0; start = 1'b0; row = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 'x;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // preload memory[k] = k through the write port
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(k); wr_data = DW'(k);
      tick();
      model_mem[k] = DW'(k);
    end
    wr_en = 1'b0;

    // row 3, full throughput, then with backpressure
    run_row(3, 0, 1'b0, 1'b0);
    run_row(3, 1, 1'b0, 1'b0);

    // out-of-range row, then a valid last row on the next cycle
    start = 1'b1; row = ROW_W'(100);
    tick();
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_valid", out_valid, 0);
    run_row(99, 0, 1'b0, 1'b0);

    // runtime write, then read/write collision on the beat-1 load edge
    wr(40, 32'hDEADBEEF);
    run_row(1, 0, 1'b0, 1'b1);

    // asynchronous reset during beat 2
    start = 1'b1; row = ROW_W'(2);
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("pre_abort_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_abort");
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("after_abort");
    run_row(0, 0, 1'b0, 1'b0);
    run_row(1, 1, 1'b0, 1'b0);

    // start while busy is ignored
    run_row(5, 0, 1'b1, 1'b0);

    // randomized rows, writes (some out of range) and bad starts
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(1, 4)) begin
        if ($urandom_range(0, 3) == 0)
          wr($urandom_range(DEPTH, (1 << ADDR_W) - 1), $urandom);
        else
          wr($urandom_range(0, DEPTH-1), $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1; row = ROW_W'($urandom_range(IN_N, (1 << ROW_W) - 1));
        tick();
        start = 1'b0;
        check("rand_err_pulse", err, 1);
        tick();
        check("rand_err_drop", err, 0);
        check("rand_err_busy", busy, 0);
      end
      r = $urandom_range(0, IN_N-1);
      run_row(r, 2, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
